// File: rtl/ram_bist_ctrl.sv
// Write/read-back self test master for a single-port RAM macro.
// Optional second, inverted-pattern pass is enabled by defining BIST_INVERT_PASS_EN.
module ram_bist_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int SEED   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    output logic              ram_cs,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] a, a_nxt;
    logic [ADDR_W:0]   err_nxt;
    logic [ADDR_W-1:0] first_nxt, addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              wr_nxt, cs_nxt, rd_nxt;
    logic              inv_q;
`ifdef BIST_INVERT_PASS_EN
    logic              inv_nxt;
`else
    assign inv_q = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] x, input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'({x, 1'b0}) + DATA_W'(SEED);
        return inv ? ~p : p;
    endfunction

    assign busy = (state == WRITE) || (state == READ) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        err_nxt   = err_count;
        first_nxt = first_err_addr;
        addr_nxt  = ram_addr;
        din_nxt   = ram_data_in;
        wr_nxt    = 1'b0;
        cs_nxt    = 1'b0;
        rd_nxt    = 1'b0;
`ifdef BIST_INVERT_PASS_EN
        inv_nxt   = inv_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WRITE;
                    a_nxt     = '0;
                    err_nxt   = '0;
                    first_nxt = '0;
                    addr_nxt  = '0;
                    din_nxt   = pat('0, 1'b0);
                    cs_nxt    = 1'b1;
                    wr_nxt    = 1'b1;
`ifdef BIST_INVERT_PASS_EN
                    inv_nxt   = 1'b0;
`endif
                end
            end
            WRITE: begin
                cs_nxt = 1'b1;
                if (a == LAST) begin
                    state_nxt = READ;
                    a_nxt     = '0;
                    addr_nxt  = '0;
                    rd_nxt    = 1'b1;
                end else begin
                    a_nxt    = a + 1'b1;
                    addr_nxt = a + 1'b1;
                    din_nxt  = pat(a + 1'b1, inv_q);
                    wr_nxt   = 1'b1;
                end
            end
            READ: begin
                state_nxt = CHECK;
                cs_nxt    = 1'b1;
                rd_nxt    = 1'b1;
            end
            CHECK: begin
                if (ram_data_out != pat(a, inv_q)) begin
                    err_nxt = err_count + 1'b1;
                    if (err_count == '0)
                        first_nxt = a;
                end
                if (a == LAST) begin
                    state_nxt = DONE;
`ifdef BIST_INVERT_PASS_EN
                    // Second sweep re-runs the whole write/read cycle with inverted data.
                    if (!inv_q) begin
                        state_nxt = WRITE;
                        inv_nxt   = 1'b1;
                        a_nxt     = '0;
                        addr_nxt  = '0;
                        din_nxt   = pat('0, 1'b1);
                        cs_nxt    = 1'b1;
                        wr_nxt    = 1'b1;
                    end
`endif
                end else begin
                    state_nxt = READ;
                    a_nxt     = a + 1'b1;
                    addr_nxt  = a + 1'b1;
                    cs_nxt    = 1'b1;
                    rd_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            a              <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            ram_addr       <= '0;
            ram_data_in    <= '0;
            ram_wr         <= 1'b0;
            ram_cs         <= 1'b0;
            ram_rd         <= 1'b0;
        end else begin
            state          <= state_nxt;
            a              <= a_nxt;
            err_count      <= err_nxt;
            first_err_addr <= first_nxt;
            ram_addr       <= addr_nxt;
            ram_data_in    <= din_nxt;
            ram_wr         <= wr_nxt;
            ram_cs         <= cs_nxt;
            ram_rd         <= rd_nxt;
        end
    end

`ifdef BIST_INVERT_PASS_EN
    always_ff @(posedge clk) begin
        if (rst) inv_q <= 1'b0;
        else     inv_q <= inv_nxt;
    end
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural 1024x8 RAM with per-location stuck-at masks.
module tb_ram_bist_ctrl;

`ifdef BIST_INVERT_PASS_EN
    localparam int SWEEPS = 2;
`else
    localparam int SWEEPS = 1;
`endif
    localparam int RUN_CYC = 3 * 1024 * SWEEPS;
    localparam int LIMIT   = RUN_CYC + 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr, ram_addr;
    logic [7:0]  ram_data_in, ram_data_out;
    logic        ram_wr, ram_cs, ram_rd;

    ram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_wr(ram_wr), .ram_cs(ram_cs), .ram_rd(ram_rd),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem   [0:1023];
    logic [7:0] set_m [0:1023];
    logic [7:0] clr_m [0:1023];

    always @(posedge clk)
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_data_in;

    assign ram_data_out = (mem[ram_addr] | set_m[ram_addr]) & ~clr_m[ram_addr];

    // Protocol / pattern monitor, cleared on request between runs.
    int         wr_cnt [0:1023];
    int         rd_cnt [0:1023];
    int         proto_bad;
    logic [7:0] seen200;
    logic       mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int i = 0; i < 1024; i++) begin
                wr_cnt[i] = 0;
                rd_cnt[i] = 0;
            end
            proto_bad = 0;
            seen200   = 8'h00;
        end else begin
            if (ram_wr && ram_rd) proto_bad++;
            if ((ram_wr || ram_rd) && !ram_cs) proto_bad++;
            if (ram_cs && ram_wr) begin
                logic [7:0] p;
                p = 8'(2 * int'(ram_addr));
                if (wr_cnt[ram_addr] != 0) p = ~p;
                if (ram_data_in != p) proto_bad++;
                if (ram_addr == 10'd200 && wr_cnt[200] == 0) seen200 = ram_data_in;
                wr_cnt[ram_addr]++;
            end
            if (ram_cs && ram_rd) rd_cnt[ram_addr]++;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        string      name;
        int         f0_addr;
        logic [7:0] f0_set, f0_clr;
        int         f1_addr;
        logic [7:0] f1_set, f1_clr;
        logic       exp_pass;
        int         exp_err;
        int         exp_first;
    } vec_t;

    vec_t vecs [6];

    task automatic clear_faults();
        for (int i = 0; i < 1024; i++) begin
            set_m[i] = 8'h00;
            clr_m[i] = 8'h00;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    function automatic int count_bad();
        int bad = 0;
        for (int i = 0; i < 1024; i++)
            if (wr_cnt[i] != SWEEPS || rd_cnt[i] != 2 * SWEEPS) bad++;
        return bad;
    endfunction

    logic [63:0] outs;
    assign outs = {busy, done, pass, err_count, first_err_addr, ram_addr,
                   ram_data_in, ram_wr, ram_cs, ram_rd};

    initial begin
        int n;
        vecs[0] = '{"good",      0,   8'h00, 8'h00, 0,   8'h00, 8'h00, 1'b1, 0, 0};
        vecs[1] = '{"sa1_b0_5",  5,   8'h01, 8'h00, 0,   8'h00, 8'h00, 1'b0, 1, 5};
        vecs[2] = '{"sa0_b7_70", 70,  8'h00, 8'h80, 90,  8'h00, 8'h80, 1'b0, 2, 70};
        vecs[3] = '{"sa1_b7_0",  0,   8'h80, 8'h00, 0,   8'h00, 8'h00, 1'b0, 1, 0};
        vecs[4] = '{"sa0_1023",  1023,8'h00, 8'hFE, 0,   8'h00, 8'h00, 1'b0, 1, 1023};
        vecs[5] = '{"order",     600, 8'h01, 8'h00, 300, 8'h00, 8'h08, 1'b0, 2, 300};

        clear_faults();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_faults();
            set_m[vecs[v].f0_addr] = vecs[v].f0_set;
            clr_m[vecs[v].f0_addr] = vecs[v].f0_clr;
            set_m[vecs[v].f1_addr] = set_m[vecs[v].f1_addr] | vecs[v].f1_set;
            clr_m[vecs[v].f1_addr] = clr_m[vecs[v].f1_addr] | vecs[v].f1_clr;
            clear_monitor();
            pulse_start();
            wait_done(0, n);
            chk({vecs[v].name, "_latency"}, 64'(n), 64'(RUN_CYC));
            chk({vecs[v].name, "_pass"}, 64'(pass), 64'(vecs[v].exp_pass));
            chk({vecs[v].name, "_err"}, 64'(err_count), 64'(vecs[v].exp_err));
            if (vecs[v].exp_err != 0)
                chk({vecs[v].name, "_first"}, 64'(first_err_addr), 64'(vecs[v].exp_first));
            chk({vecs[v].name, "_protocol"}, 64'(proto_bad), 64'd0);
            chk({vecs[v].name, "_wr_rd_counts"}, 64'(count_bad()), 64'd0);
            chk({vecs[v].name, "_pat_200"}, 64'(seen200), 64'd144);
        end

        // Start while in DONE after a faulty run: results must clear on the next cycle.
        clear_faults();
        set_m[5] = 8'h01;
        pulse_start();
        wait_done(0, n);
        chk("pre_restart_err", 64'(err_count), 64'd1);
        pulse_start();
        chk("restart_clear", {busy, done, pass, err_count, first_err_addr, ram_addr, ram_wr},
            {1'b1, 1'b0, 1'b0, 11'd0, 10'd0, 10'd0, 1'b1});
        wait_done(0, n);
        chk("restart_latency", 64'(n), 64'(RUN_CYC));
        chk("restart_err", 64'(err_count), 64'd1);

        // Reset mid-run at edge 1500, then a clean rerun.
        clear_faults();
        pulse_start();
        repeat (1499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", outs, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stays_idle", {busy, done}, 64'd0);
        pulse_start();
        wait_done(0, n);
        chk("after_abort_latency", 64'(n), 64'(RUN_CYC));
        chk("after_abort_pass", 64'(pass), 64'd1);

        // Start pulse while busy at edge 10 must be ignored.
        pulse_start();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", 64'(busy), 64'd1);
        wait_done(10, n);
        chk("busy_start_latency", 64'(n), 64'(RUN_CYC));
        chk("busy_start_pass", 64'(pass), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_holds", {done, pass, busy, ram_cs}, {1'b1, 1'b1, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
